block_slot_scheduler: RTL and testbench

//  Shares one 2-bit block-pattern ROM among NUM_SLOTS on-screen block windows.

---
 rtl/block_slot_scheduler_if.sv | 43 ++++
 rtl/block_slot_scheduler.sv | 165 ++++++++++++++++
 tb/tb_block_slot_scheduler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/block_slot_scheduler_if.sv
// Slot scheduler bus: raster position, slot config, shared ROM port, pixel out.
// master = timing/config/ROM side, slave = block_slot_scheduler.
interface block_slot_scheduler_if #(
  parameter int AW = 13,
  parameter int SW = 2
);
  // raster position from the timing generator
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  // slot configuration write port
  logic          cfg_we;
  logic [SW-1:0] cfg_slot;
  logic [10:0]   cfg_x;
  logic [9:0]    cfg_y;
  logic [7:0]    cfg_color;
  logic          cfg_en;
  logic          cfg_pend;
  // shared pattern ROM
  logic [AW-1:0] rom_addr;
  logic [1:0]    rom_data;
  // composed pixel
  logic [7:0]    pixel_out;
  logic          pixel_vld;
  logic [SW-1:0] pixel_slot;

  modport master (
    output hcount, vcount,
    output cfg_we, cfg_slot, cfg_x,
    output cfg_y, cfg_color, cfg_en,
    output rom_data,
    input  cfg_pend, rom_addr,
    input  pixel_out, pixel_vld, pixel_slot
  );

  modport slave (
    input  hcount, vcount,
    input  cfg_we, cfg_slot, cfg_x,
    input  cfg_y, cfg_color, cfg_en,
    input  rom_data,
    output cfg_pend, rom_addr,
    output pixel_out, pixel_vld, pixel_slot
  );
endinterface

// File: rtl/block_slot_scheduler.sv
// Shares one 2-bit block ROM among NUM_SLOTS windows, picks a winner per pixel.
// Ports: vclk, rst (async, active-high), bus (slave modport of the _if).
// Shadow config swaps into active regs at frame start (hcount==0 && vcount==0).
// Pipeline: S0 registers rom_addr, ROM reads, S2 registers the pixel,
// so pixel_out trails rom_addr by two clocks.
module block_slot_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int BLK_W     = 78,
  parameter int BLK_H     = 53,
  parameter int AW        = 13,
  parameter int IDLE_ADDR = 77
) (
  input  logic                 vclk,
  input  logic                 rst,
  block_slot_scheduler_if.slave bus
);
  localparam int SW = $clog2(NUM_SLOTS);

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [7:0]  color;
    logic        en;
  } slot_t;

  slot_t          shd [NUM_SLOTS];
  slot_t          act [NUM_SLOTS];
  slot_t          wr;
  logic [AW-1:0]  cnt [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] hit;
  logic [NUM_SLOTS-1:0] past;
  logic           fs;
  logic           win;
  logic [SW-1:0]  wsel;

  logic           cfg_pend;
  logic [AW-1:0]  rom_addr;
  logic           win_d0;
  logic [SW-1:0]  slot_d0;
  logic [7:0]     col_d0;
  logic           win_d1;
  logic [SW-1:0]  slot_d1;
  logic [7:0]     col_d1;
  logic [7:0]     pixel_out;
  logic           pixel_vld;
  logic [SW-1:0]  pixel_slot;

  assign fs = (bus.hcount == 11'd0)
           && (bus.vcount == 10'd0);

  assign wr = {bus.cfg_x, bus.cfg_y,
               bus.cfg_color, bus.cfg_en};

  // widened compares so x+BLK_W / y+BLK_H never wrap
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit[i] = act[i].en
        && ({1'b0, bus.hcount} >= {1'b0, act[i].x})
        && ({1'b0, bus.hcount} <
            ({1'b0, act[i].x} + 12'(BLK_W)))
        && ({1'b0, bus.vcount} >= {1'b0, act[i].y})
        && ({1'b0, bus.vcount} <
            ({1'b0, act[i].y} + 11'(BLK_H)));
      past[i] = {1'b0, bus.vcount} >=
                ({1'b0, act[i].y} + 11'(BLK_H));
    end
  end

  // lowest index wins: scan downwards, last hit kept
  always_comb begin
    win  = 1'b0;
    wsel = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win  = 1'b1;
        wsel = SW'(i);
      end
    end
  end

  // shadow write can coincide with fs: the swap
  // reads the old shadow, so the new write waits
  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shd[i] <= '0;
        act[i] <= '0;
      end
      cfg_pend <= 1'b0;
    end else begin
      if (fs) begin
        for (int i = 0; i < NUM_SLOTS; i++)
          act[i] <= shd[i];
      end
      if (bus.cfg_we)
        shd[bus.cfg_slot] <= wr;
      if (bus.cfg_we)
        cfg_pend <= 1'b1;
      else if (fs)
        cfg_pend <= 1'b0;
    end
  end

  // each slot walks its own address, win or lose
  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (fs || past[i])
          cnt[i] <= '0;
        else if (hit[i])
          cnt[i] <= cnt[i] + AW'(1);
      end
    end
  end

  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      rom_addr <= AW'(IDLE_ADDR);
      win_d0   <= 1'b0;
      slot_d0  <= '0;
      col_d0   <= '0;
      win_d1   <= 1'b0;
      slot_d1  <= '0;
      col_d1   <= '0;
    end else begin
      rom_addr <= win ? cnt[wsel]
                      : AW'(IDLE_ADDR);
      win_d0   <= win;
      slot_d0  <= wsel;
      col_d0   <= act[wsel].color;
      win_d1   <= win_d0;
      slot_d1  <= slot_d0;
      col_d1   <= col_d0;
    end
  end

  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      pixel_out  <= '0;
      pixel_vld  <= 1'b0;
      pixel_slot <= '0;
    end else begin
      pixel_vld  <= win_d1;
      pixel_slot <= slot_d1;
      if (!win_d1)
        pixel_out <= 8'h00;
      else begin
        unique case (bus.rom_data)
          2'b00:   pixel_out <= 8'h00;
          2'b11:   pixel_out <= 8'hFF;
          default: pixel_out <= col_d1;
        endcase
      end
    end
  end

  assign bus.cfg_pend   = cfg_pend;
  assign bus.rom_addr   = rom_addr;
  assign bus.pixel_out  = pixel_out;
  assign bus.pixel_vld  = pixel_vld;
  assign bus.pixel_slot = pixel_slot;
endmodule

// File: tb/tb_block_slot_scheduler.sv
// Directed bench for block_slot_scheduler.
// Raster is driven directly; ROM model returns rom_addr[1:0].
module tb_block_slot_scheduler;
  logic vclk = 1'b0;
  logic rst  = 1'b1;

  block_slot_scheduler_if bus ();

  block_slot_scheduler dut (
    .vclk (vclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 vclk = ~vclk;

  always @(posedge vclk)
    bus.rom_data <= bus.rom_addr[1:0];

  int n_chk = 0;
  int n_err = 0;
  int q_addr[$];
  int q_pix[$];
  int q_vld[$];
  int q_slot[$];
  int sh0, sh1, sv0;
  int nv;

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step(input int h, input int v);
    bus.hcount = 11'(h);
    bus.vcount = 10'(v);
    @(posedge vclk);
    #1;
  endtask

  task automatic rec();
    q_addr.push_back(int'(bus.rom_addr));
    q_pix.push_back(int'(bus.pixel_out));
    q_vld.push_back(int'(bus.pixel_vld));
    q_slot.push_back(int'(bus.pixel_slot));
  endtask

  task automatic cfg_write(input int s, input int x,
                           input int y, input int c,
                           input int en, input int h,
                           input int v);
    bus.cfg_slot  = 2'(s);
    bus.cfg_x     = 11'(x);
    bus.cfg_y     = 10'(y);
    bus.cfg_color = 8'(c);
    bus.cfg_en    = 1'(en);
    bus.cfg_we    = 1'b1;
    step(h, v);
    bus.cfg_we    = 1'b0;
  endtask

  // raster sweep of a rectangle, then two idle
  // steps at (1,1) to drain the pixel pipeline
  task automatic sweep(input int h0, input int h1,
                       input int v0, input int v1,
                       output int nvld);
    q_addr.delete();
    q_pix.delete();
    q_vld.delete();
    q_slot.delete();
    sh0 = h0; sh1 = h1; sv0 = v0;
    nvld = 0;
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++) begin
        step(h, v);
        rec();
      end
    for (int k = 0; k < 2; k++) begin
      step(1, 1);
      rec();
    end
    foreach (q_vld[k]) nvld += q_vld[k];
  endtask

  function automatic int at(input int h, input int v);
    return (v - sv0) * (sh1 - sh0 + 1) + (h - sh0);
  endfunction

  function automatic int addr_at(input int h, input int v);
    return q_addr[at(h, v)];
  endfunction

  function automatic int pix_at(input int h, input int v);
    return q_pix[at(h, v) + 2];
  endfunction

  function automatic int vld_at(input int h, input int v);
    return q_vld[at(h, v) + 2];
  endfunction

  function automatic int slot_at(input int h, input int v);
    return q_slot[at(h, v) + 2];
  endfunction

  initial begin
    bus.hcount    = 11'd1;
    bus.vcount    = 10'd1;
    bus.cfg_we    = 1'b0;
    bus.cfg_slot  = '0;
    bus.cfg_x     = '0;
    bus.cfg_y     = '0;
    bus.cfg_color = '0;
    bus.cfg_en    = 1'b0;
    repeat (3) @(posedge vclk);
    #1;
    chk("rst_addr", int'(bus.rom_addr), 77);
    chk("rst_vld", int'(bus.pixel_vld), 0);
    chk("rst_pix", int'(bus.pixel_out), 0);
    chk("rst_slot", int'(bus.pixel_slot), 0);
    chk("rst_pend", int'(bus.cfg_pend), 0);
    @(negedge vclk);
    rst = 1'b0;

    // T1: async reset mid-frame
    cfg_write(0, 338, 485, 'hE0, 1, 1, 1);
    chk("t1_pend_set", int'(bus.cfg_pend), 1);
    step(0, 0);
    chk("t1_pend_clr", int'(bus.cfg_pend), 0);
    sweep(330, 420, 485, 490, nv);
    chk("t1_pre_nvld", nv, 468);
    cfg_write(1, 10, 10, 'h11, 1, 1, 1);
    step(380, 487);
    #1 rst = 1'b1;
    #1;
    chk("t1_addr", int'(bus.rom_addr), 77);
    chk("t1_vld", int'(bus.pixel_vld), 0);
    chk("t1_pend", int'(bus.cfg_pend), 0);
    chk("t1_pix", int'(bus.pixel_out), 0);
    @(negedge vclk);
    rst = 1'b0;
    step(0, 0);
    sweep(330, 420, 484, 490, nv);
    chk("t1_post_nvld", nv, 0);
    sweep(5, 90, 9, 12, nv);
    chk("t1_slot1_nvld", nv, 0);

    // T2: single slot full window
    cfg_write(0, 338, 485, 'hE0, 1, 1, 1);
    step(0, 0);
    sweep(336, 418, 484, 539, nv);
    chk("t2_nvld", nv, 4134);
    chk("t2_addr_first", addr_at(338, 485), 0);
    chk("t2_addr_1", addr_at(339, 485), 1);
    chk("t2_addr_row1", addr_at(338, 486), 78);
    chk("t2_addr_last", addr_at(415, 537), 4133);
    chk("t2_addr_left", addr_at(337, 485), 77);
    chk("t2_addr_right", addr_at(416, 485), 77);
    chk("t2_addr_below", addr_at(338, 538), 77);
    chk("t2_pix_00", pix_at(338, 485), 'h00);
    chk("t2_vld_00", vld_at(338, 485), 1);
    chk("t2_pix_01", pix_at(339, 485), 'hE0);
    chk("t2_pix_10", pix_at(340, 485), 'hE0);
    chk("t2_pix_11", pix_at(341, 485), 'hFF);
    chk("t2_vld_out", vld_at(337, 485), 0);
    chk("t2_pix_out", pix_at(337, 485), 0);

    // T3: overlap, slot 0 wins, slot 2 keeps counting
    cfg_write(0, 100, 100, 'h3C, 1, 1, 1);
    cfg_write(2, 150, 120, 'hC3, 1, 1, 1);
    step(0, 0);
    sweep(95, 240, 100, 125, nv);
    chk("t3_ovl_slot", slot_at(160, 125), 0);
    chk("t3_ovl_vld", vld_at(160, 125), 1);
    chk("t3_ovl_addr", addr_at(150, 120), 1610);
    chk("t3_ovl_pix", pix_at(150, 120), 'h3C);
    chk("t3_s2_addr", addr_at(178, 120), 28);
    chk("t3_s2_slot", slot_at(178, 120), 2);
    chk("t3_s2_pix", pix_at(179, 120), 'hC3);
    chk("t3_s2_row1", addr_at(178, 121), 106);

    // T4: deferred config
    cfg_write(1, 600, 310, 'h5A, 1, 500, 300);
    chk("t4_pend", int'(bus.cfg_pend), 1);
    sweep(598, 606, 309, 311, nv);
    chk("t4_pre_nvld", nv, 0);
    step(0, 0);
    chk("t4_pend_clr", int'(bus.cfg_pend), 0);
    sweep(598, 606, 309, 311, nv);
    chk("t4_nvld", nv, 14);
    chk("t4_addr", addr_at(600, 310), 0);
    chk("t4_addr_end", addr_at(606, 310), 6);
    chk("t4_slot", slot_at(601, 310), 1);
    chk("t4_pix", pix_at(601, 310), 'h5A);

    // T5: write in the frame-start cycle
    cfg_write(3, 2000, 600, 'h77, 1, 0, 0);
    chk("t5_pend", int'(bus.cfg_pend), 1);
    sweep(1995, 2047, 600, 601, nv);
    chk("t5_pre_nvld", nv, 0);
    step(0, 0);
    chk("t5_pend_clr", int'(bus.cfg_pend), 0);

    // T6: right edge clip, counter reset below
    sweep(1990, 2047, 598, 654, nv);
    chk("t6_nvld", nv, 2544);
    chk("t6_addr0", addr_at(2000, 600), 0);
    chk("t6_addr_edge", addr_at(2047, 600), 47);
    chk("t6_pix_edge", pix_at(2047, 600), 'hFF);
    chk("t6_addr_row1", addr_at(2000, 601), 48);
    chk("t6_addr_left", addr_at(1999, 600), 77);
    chk("t6_addr_below", addr_at(2000, 653), 77);
    sweep(1998, 2047, 600, 600, nv);
    chk("t6_cnt_reset", addr_at(2000, 600), 0);
    sweep(0, 30, 600, 601, nv);
    chk("t6_no_wrap", nv, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
